// File: rtl/window_writeback_rgb888.sv
// ---------------------------------------------------------------------------
// window_writeback_rgb888
// Collects result pixels from the window/MAC stage into a small skid FIFO and
// writes them to an output frame BRAM in raster order, one pixel per granted
// write. A frame is started with iStart, accepts exactly DEPTH pixels, drains
// the FIFO and then pulses oDone for one cycle.
//
// Ports
//   iClk      : clock, rising edge
//   iRst      : asynchronous active-low reset
//   iStart    : begin a frame (only looked at while idle)
//   iValid    : result pixel present on iPixel
//   iPixel    : result pixel (RGB888)
//   oBusy     : stall request to the upstream stage
//   oCs/oWe   : BRAM write request
//   oAddr     : BRAM write address
//   oData     : BRAM write data (head of the FIFO)
//   iWrGnt    : BRAM grant; a write completes on an edge with oCs && iWrGnt
//   oCol/oRow : coordinate of the pixel currently at oAddr
//   oDone     : one-cycle end-of-frame pulse
//   oOverflow : sticky flag, a pixel was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module window_writeback_rgb888 #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 17,
  parameter int WIDTH      = 480,
  parameter int HEIGHT     = 272,
  parameter int DEPTH      = 130560,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iStart,
  input  logic                      iValid,
  input  logic [DATA_W-1:0]         iPixel,
  output logic                      oBusy,
  output logic                      oCs,
  output logic                      oWe,
  output logic [ADDR_W-1:0]         oAddr,
  output logic [DATA_W-1:0]         oData,
  input  logic                      iWrGnt,
  output logic [$clog2(WIDTH):0]    oCol,
  output logic [$clog2(HEIGHT):0]   oRow,
  output logic                      oDone,
  output logic                      oOverflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = $clog2(DEPTH + 1);
  localparam int COL_W = $clog2(WIDTH) + 1;
  localparam int ROW_W = $clog2(HEIGHT) + 1;

  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NEARFULL_C = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [ACC_W-1:0] DEPTH_C    = ACC_W'(DEPTH);
  localparam logic [COL_W-1:0] COL_LAST_C = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q;
  logic [PTR_W-1:0]    rdPtr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [ACC_W-1:0]    accCnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic                done_q;
  logic                overflow_q;

  logic                acceptOk;
  logic                push;
  logic                drop;
  logic                wrDone;

  // Accept/drop decisions use the FIFO count from before the edge, so a pop
  // on the same edge never makes room for a pixel arriving on a full FIFO.
  always_comb begin
    acceptOk = (state_q == RUN) && (accCnt_q < DEPTH_C);
    push     = acceptOk && iValid && (count_q != FULL_C);
    drop     = acceptOk && iValid && (count_q == FULL_C);
    wrDone   = oCs && iWrGnt;
    count_d  = count_q;
    if (push && !wrDone) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && wrDone) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign oCs       = ((state_q == RUN) || (state_q == FLUSH)) && (count_q != '0);
  assign oWe       = oCs;
  // Data is masked while no write is requested so the bus reads zero after
  // reset even though the storage itself is not reset.
  assign oData     = oCs ? mem_q[rdPtr_q] : '0;
  assign oAddr     = addr_q;
  assign oCol      = col_q;
  assign oRow      = row_q;
  assign oDone     = done_q;
  assign oOverflow = overflow_q;
  // Busy is raised one entry early so the upstream stage has a cycle to react.
  assign oBusy     = (state_q != RUN) || (count_q >= NEARFULL_C);

  // FIFO storage has no reset; only entries below the count are ever read.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem_q[wrPtr_q] <= iPixel;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      accCnt_q   <= '0;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q    <= RUN;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            accCnt_q   <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
          end
        end
        RUN, FLUSH: begin
          count_q <= count_d;
          if (push) begin
            wrPtr_q  <= wrPtr_q + PTR_W'(1);
            accCnt_q <= accCnt_q + ACC_W'(1);
          end
          if (drop) begin
            overflow_q <= 1'b1;
          end
          if (wrDone) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
            addr_q  <= addr_q + ADDR_W'(1);
            if (col_q == COL_LAST_C) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
          // The last accepted pixel closes the input side; the frame is done
          // on the edge that empties the FIFO afterwards.
          if ((state_q == RUN) && push && (accCnt_q == DEPTH_C - ACC_W'(1))) begin
            state_q <= FLUSH;
          end else if ((state_q == FLUSH) && (count_d == '0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_writeback_rgb888.sv
// ---------------------------------------------------------------------------
// tb_window_writeback_rgb888
// Self-checking bench for window_writeback_rgb888 with a 4x3 frame and a
// 4-entry FIFO. A hand-written vector table covers the start of a frame and
// a stalled BRAM; the rest is driven with random pixels, valids and grants
// and compared every cycle against a queue-based model of the frame.
// ---------------------------------------------------------------------------
module tb_window_writeback_rgb888;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 17;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int DEPTH  = 12;
  localparam int FD     = 4;
  localparam int COL_W  = $clog2(WIDTH) + 1;
  localparam int ROW_W  = $clog2(HEIGHT) + 1;

  logic                iClk = 1'b0;
  logic                iRst = 1'b0;
  logic                iStart = 1'b0;
  logic                iValid = 1'b0;
  logic [DATA_W-1:0]   iPixel = '0;
  logic                iWrGnt = 1'b0;
  logic                oBusy;
  logic                oCs;
  logic                oWe;
  logic [ADDR_W-1:0]   oAddr;
  logic [DATA_W-1:0]   oData;
  logic [COL_W-1:0]    oCol;
  logic [ROW_W-1:0]    oRow;
  logic                oDone;
  logic                oOverflow;

  int vecCount  = 0;
  int missCount = 0;

  // Model of the frame: whether a frame is open, how many pixels were taken
  // and written, the pixels waiting in the skid buffer, and the flags.
  bit                mOpen;
  bit                mDone;
  bit                mOvf;
  int                mAcc;
  int                mWr;
  logic [DATA_W-1:0] mQ[$];

  typedef struct {
    bit                start;
    bit                valid;
    logic [DATA_W-1:0] pixel;
    bit                gnt;
    bit                busy;
    bit                cs;
    int                addr;
    logic [DATA_W-1:0] data;
    int                col;
    int                row;
    bit                done;
    bit                ovf;
  } vec_t;

  vec_t tbl[10];

  window_writeback_rgb888 #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .DEPTH(DEPTH), .FIFO_DEPTH(FD)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iValid(iValid),
    .iPixel(iPixel), .oBusy(oBusy), .oCs(oCs), .oWe(oWe), .oAddr(oAddr),
    .oData(oData), .iWrGnt(iWrGnt), .oCol(oCol), .oRow(oRow),
    .oDone(oDone), .oOverflow(oOverflow)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  always #5 iClk = ~iClk;

  // Hard stop in case a loop bound is ever wrong.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mOpen = 1'b0;
    mDone = 1'b0;
    mOvf  = 1'b0;
    mAcc  = 0;
    mWr   = 0;
    mQ.delete();
  endtask

  function automatic bit expBusy();
    return !(mOpen && (mAcc < DEPTH)) || (mQ.size() >= FD - 1);
  endfunction

  // Advances the model by one clock edge using the pre-edge picture.
  task automatic modelStep(input bit st, input bit v, input logic [DATA_W-1:0] px, input bit g);
    bit takeIn;
    bit wr;
    bit acc;
    bit drp;
    takeIn = mOpen && (mAcc < DEPTH);
    wr     = (mQ.size() > 0) && g;
    acc    = takeIn && v && (mQ.size() < FD);
    drp    = takeIn && v && (mQ.size() == FD);
    if (!mOpen && !mDone) begin
      if (st) begin
        mOpen = 1'b1;
        mAcc  = 0;
        mWr   = 0;
        mOvf  = 1'b0;
        mQ.delete();
      end
    end else begin
      mDone = 1'b0;
      if (wr) begin
        void'(mQ.pop_front());
        mWr++;
        if (mWr == DEPTH) begin
          mOpen = 1'b0;
          mDone = 1'b1;
        end
      end
      if (acc) begin
        mQ.push_back(px);
        mAcc++;
      end
      if (drp) begin
        mOvf = 1'b1;
      end
    end
  endtask

  // Drives one cycle of inputs and returns on the following falling edge.
  task automatic applyStimulus(input bit st, input bit v, input logic [DATA_W-1:0] px, input bit g);
    iStart = st;
    iValid = v;
    iPixel = px;
    iWrGnt = g;
    modelStep(st, v, px, g);
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".busy"}, 32'(oBusy), 32'(expBusy()));
    compare({tag, ".cs"}, 32'(oCs), 32'(mQ.size() > 0));
    compare({tag, ".we"}, 32'(oWe), 32'(mQ.size() > 0));
    compare({tag, ".addr"}, 32'(oAddr), mWr);
    compare({tag, ".col"}, 32'(oCol), mWr % WIDTH);
    compare({tag, ".row"}, 32'(oRow), mWr / WIDTH);
    compare({tag, ".done"}, 32'(oDone), 32'(mDone));
    compare({tag, ".ovf"}, 32'(oOverflow), 32'(mOvf));
    if (mQ.size() > 0) begin
      compare({tag, ".data"}, 32'(oData), 32'(mQ[0]));
    end
  endtask

  task automatic checkTable(input int i);
    string tag;
    tag = $sformatf("tbl%0d", i);
    compare({tag, ".busy"}, 32'(oBusy), 32'(tbl[i].busy));
    compare({tag, ".cs"}, 32'(oCs), 32'(tbl[i].cs));
    compare({tag, ".we"}, 32'(oWe), 32'(tbl[i].cs));
    compare({tag, ".addr"}, 32'(oAddr), tbl[i].addr);
    compare({tag, ".col"}, 32'(oCol), tbl[i].col);
    compare({tag, ".row"}, 32'(oRow), tbl[i].row);
    compare({tag, ".done"}, 32'(oDone), 32'(tbl[i].done));
    compare({tag, ".ovf"}, 32'(oOverflow), 32'(tbl[i].ovf));
    if (tbl[i].cs) begin
      compare({tag, ".data"}, 32'(oData), 32'(tbl[i].data));
    end
  endtask

  // Runs random traffic until the model's end-of-frame pulse, then one idle
  // cycle so the next iStart lands in idle.
  task automatic runUntilDone(input string tag, input int validPct, input int gntPct,
                              input bit honorBusy, input bit randStart, input int budget);
    int  cyc;
    bit  seen;
    bit  v;
    bit  g;
    bit  st;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && (cyc < budget)) begin
      v  = ($urandom_range(99) < validPct) && (!honorBusy || !expBusy());
      g  = $urandom_range(99) < gntPct;
      st = randStart && ($urandom_range(7) == 0);
      applyStimulus(st, v, DATA_W'($urandom), g);
      checkOutput(tag);
      seen = mDone;
      cyc++;
    end
    if (!seen) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s.timeout: got no end of frame within %0d cycles, required one", tag, budget);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput({tag, ".post"});
  endtask

  initial begin
    int guard;

    //            st  v   pixel      g  busy cs addr data       col row done ovf
    tbl[0] = '{1'b1, 1'b0, 24'h0,    1'b1, 1'b0, 1'b0, 0, 24'h0,  0, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 24'h11,   1'b1, 1'b0, 1'b1, 0, 24'h11, 0, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 24'h22,   1'b1, 1'b0, 1'b1, 1, 24'h22, 1, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 24'h0,    1'b1, 1'b0, 1'b0, 2, 24'h0,  2, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 24'h33,   1'b0, 1'b0, 1'b1, 2, 24'h33, 2, 0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 24'h44,   1'b0, 1'b0, 1'b1, 2, 24'h33, 2, 0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 24'h55,   1'b0, 1'b1, 1'b1, 2, 24'h33, 2, 0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 24'h0,    1'b1, 1'b0, 1'b1, 3, 24'h44, 3, 0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 24'h0,    1'b1, 1'b0, 1'b1, 4, 24'h55, 0, 1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 24'h0,    1'b1, 1'b0, 1'b0, 5, 24'h0,  1, 1, 1'b0, 1'b0};

    $display("[TB] start");
    modelReset();
    repeat (2) @(negedge iClk);
    checkOutput("reset");
    compare("reset.data", 32'(oData), 32'h0);
    iRst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("idle");

    // Frame opening, a stalled BRAM filling the FIFO, then draining in order.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].start, tbl[i].valid, tbl[i].pixel, tbl[i].gnt);
      checkTable(i);
    end
    // Finish that frame with random traffic and stray iStart pulses.
    runUntilDone("rest", 70, 70, 1'b1, 1'b1, 300);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("hold");

    // Clean frame: pixels 1..12 back to back with the BRAM always granting.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("clean.start");
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'(k), 1'b1);
      checkOutput("clean");
    end
    runUntilDone("clean.end", 0, 100, 1'b1, 1'b0, 20);

    // Upstream ignores busy while the BRAM is stalled: the fifth pixel drops.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("ovf.start");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'(32'h100 + k), 1'b0);
      checkOutput("ovf.fill");
    end
    compare("ovf.flag", 32'(oOverflow), 32'h1);
    runUntilDone("ovf.drain", 100, 100, 1'b0, 1'b0, 100);

    // Extra valids after the last accepted pixel are ignored without a flag.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("extra.start");
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b0, 1'b1, DATA_W'($urandom), 1'b1);
      checkOutput("extra.fill");
    end
    runUntilDone("extra.tail", 100, 100, 1'b0, 1'b0, 30);
    compare("extra.ovf", 32'(oOverflow), 32'h0);

    // Reset in the middle of a frame after six writes, then a fresh frame.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("mrst.start");
    guard = 0;
    while ((mWr < 6) && (guard < 40)) begin
      applyStimulus(1'b0, !expBusy(), DATA_W'($urandom), 1'b1);
      checkOutput("mrst.run");
      guard++;
    end
    compare("mrst.writes", mWr, 6);
    iRst = 1'b0;
    #1;
    modelReset();
    checkOutput("mrst.async");
    compare("mrst.data", 32'(oData), 32'h0);
    @(posedge iClk);
    @(negedge iClk);
    checkOutput("mrst.held");
    iRst = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("mrst.restart");
    runUntilDone("mrst.frame", 80, 80, 1'b1, 1'b0, 300);

    // A few fully random frames with stray iStart pulses.
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("rnd.start");
      runUntilDone("rnd", 30 + 20 * f, 40 + 20 * f, f != 1, 1'b1, 400);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/window_writeback_rgb888.md
WINDOW_WRITEBACK_RGB888 -- requirements
Module: window_writeback_rgb888

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width (RGB888).
REQ-002 SHALL have parameter ADDR_W, default 17, output BRAM address width.
REQ-003 SHALL have parameter WIDTH, default 480, pixels per row.
REQ-004 SHALL have parameter HEIGHT, default 272, rows per frame.
REQ-005 SHALL have parameter DEPTH, default 130560, pixels per frame; must equal WIDTH*HEIGHT.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, skid FIFO entries (power of 2, >=2).
REQ-007 SHALL have port iClk, input, 1, clock, all logic on rising edge.
REQ-008 SHALL have port iRst, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port iStart, input, 1, begin frame; sampled in IDLE only.
REQ-010 SHALL have port iValid, input, 1, result pixel present on iPixel.
REQ-011 SHALL have port iPixel, input, DATA_W, result pixel from MAC stage.
REQ-012 SHALL have port oBusy, output, 1, stall request to upstream window/MAC stage.
REQ-013 SHALL have ports oCs and oWe, output, 1 each, BRAM write request.
REQ-014 SHALL have port oAddr, output, ADDR_W, BRAM write address.
REQ-015 SHALL have port oData, output, DATA_W, BRAM write data.
REQ-016 SHALL have port iWrGnt, input, 1, BRAM port grant; a write completes on an edge where oCs&&iWrGnt.
REQ-017 SHALL have ports oCol and oRow, output, clog2(WIDTH)+1 and clog2(HEIGHT)+1 bits, coordinate of the pixel at oAddr.
REQ-018 SHALL have port oDone, output, 1, one-cycle end-of-frame pulse.
REQ-019 SHALL have port oOverflow, output, 1, sticky dropped-pixel flag.

Function
REQ-020 SHALL implement FSM IDLE, RUN, FLUSH, DONE.
REQ-021 IDLE: iStart=1 -> RUN; in the same edge, clear accept counter, write address, oCol, oRow, FIFO, and oOverflow.
REQ-022 RUN: accept a pixel on an edge where iValid=1, FIFO count<FIFO_DEPTH, and accepted<DEPTH; push iPixel.
REQ-023 RUN: accepted count reaching DEPTH -> FLUSH; iValid thereafter ignored, no flag.
REQ-024 iValid=1 in RUN with FIFO full SHALL drop the pixel, not count it, and set oOverflow until next iStart or reset.
REQ-025 Accept test uses count before the edge; a pop on the same edge does not free a slot; simultaneous push+pop leaves count unchanged.
REQ-026 oBusy SHALL be 1 when state!=RUN or FIFO count>=FIFO_DEPTH-1; combinational from registered state/count.
REQ-027 oCs=oWe=1 when state is RUN or FLUSH and FIFO non-empty; oData = FIFO head; oAddr = write address.
REQ-028 A pixel pushed into an empty FIFO at edge N SHALL appear on oCs/oData from cycle N+1 (1-cycle latency).
REQ-029 On a completed write: pop FIFO, increment oAddr; oCol increments, wraps WIDTH-1 -> 0 with oRow+1.
REQ-030 oAddr SHALL always equal oRow*WIDTH+oCol; writes strictly in raster order 0..DEPTH-1.
REQ-031 oCs held with iWrGnt=0 SHALL keep oAddr/oData stable until granted.
REQ-032 FLUSH: FIFO empty after final write (oAddr=DEPTH) -> DONE; DONE: oDone=1 for one cycle -> IDLE.
REQ-033 iStart in RUN, FLUSH, or DONE SHALL be ignored.
REQ-034 oAddr/oCol/oRow SHALL hold final values in IDLE until next iStart.

Reset
REQ-035 iRst=0 at any time SHALL force IDLE, empty FIFO, and zero counters; no partial write continues.
REQ-036 Reset values: oCs=oWe=0, oAddr=0, oData=0, oCol=0, oRow=0, oDone=0, oOverflow=0, oBusy=1.

Verification (WIDTH=4, HEIGHT=3, DEPTH=12, FIFO_DEPTH=4)
REQ-037 iStart, then 12 iValid pixels 0x000001..0x00000C with iWrGnt=1 -> writes addr 0..11 with matching data, last at (oCol=3, oRow=2), one oDone pulse.
REQ-038 iWrGnt=0 while 3 pixels pushed -> oBusy=1 once count=3, oAddr/oData stable; iWrGnt=1 -> drain in order, oBusy=0.
REQ-039 iWrGnt=0, ignore oBusy, drive 5 pixels -> 4 stored, oOverflow=1, 12-pixel frame finishes only after 13 valids.
REQ-040 Drive a 13th valid after 12 accepted -> ignored, no overflow, oDone once.
REQ-041 iRst low mid-frame after 6 writes -> outputs at reset values; new iStart restarts at addr 0.
REQ-042 iStart pulsed during RUN -> no effect on counters or address sequence.
